// File: rtl/fetch_tracker_pkg.sv
// Shared types for the fetch tracker: the trace record, the queued pending
// fetch, and the request-side FSM states.
package ryuki_datatypes;

    localparam int REC_ADDR_W = 32;
    localparam int REC_DATA_W = 32;
    localparam int TS_W       = 32;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_DATA_W-1:0] instruction;
        logic [TS_W-1:0]       time_req;
        logic [TS_W-1:0]       time_gnt;
        logic [TS_W-1:0]       time_end;
    } fetch_record_t;

    // A granted fetch still waiting for its rvalid beat.
    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [TS_W-1:0]       time_req;
        logic [TS_W-1:0]       time_gnt;
    } pending_entry_t;

    typedef enum logic {
        REQ_IDLE,
        REQ_WAIT_GNT
    } req_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is accepted only
// when a pop happens in the same cycle, a pop while empty is ignored.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fetch_tracker.sv
// Passive instruction-fetch snooper producing one timestamped trace record per
// completed fetch. Define FETCH_TRACKER_DROP_CNT_EN to add the drop_count output.
module fetch_tracker
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               instr_req,
    input  logic [ADDR_WIDTH-1:0]              instr_addr,
    input  logic                               instr_grant,
    input  logic                               instr_rvalid,
    input  logic [DATA_WIDTH-1:0]              instr_rdata,
    input  logic [31:0]                        counter,
    output logic                               trace_valid,
    input  logic                               trace_ready,
    output fetch_record_t                      trace_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               overflow,
    output logic                               protocol_err
`ifdef FETCH_TRACKER_DROP_CNT_EN
    ,
    output logic [15:0]                        drop_count
`endif
);

    localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

    req_state_e     state_q;
    req_state_e     state_d;
    logic [TS_W-1:0] time_req_q;
    logic [TS_W-1:0] time_req;

    pending_entry_t pend_in;
    pending_entry_t pend_head;
    logic           pend_full;
    logic           pend_empty;
    fetch_record_t  rec_in;
    fetch_record_t  out_head;
    logic           out_full;
    logic           out_empty;

    logic fetch_granted;
    logic pend_hit;
    logic pend_accept;
    logic grant_drop;
    logic out_pop;
    logic rec_drop;

    assign fetch_granted = instr_req & instr_grant;
    assign pend_hit      = instr_rvalid & ~pend_empty;
    assign pend_accept   = fetch_granted & (~pend_full | pend_hit);
    assign grant_drop    = fetch_granted & pend_full & ~instr_rvalid;
    assign out_pop       = trace_valid & trace_ready;
    assign rec_drop      = pend_hit & out_full & ~out_pop;

    // A request granted in its first cycle has no earlier start time to report.
    assign time_req = (state_q == REQ_IDLE) ? counter : time_req_q;

    assign pend_in = '{addr: REC_ADDR_W'(instr_addr), time_req: time_req, time_gnt: counter};
    assign rec_in  = '{addr:        pend_head.addr,
                       instruction: REC_DATA_W'(instr_rdata),
                       time_req:    pend_head.time_req,
                       time_gnt:    pend_head.time_gnt,
                       time_end:    counter};

    assign trace_valid = ~out_empty;
    assign trace_o     = trace_valid ? out_head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ_IDLE;
            time_req_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REQ_IDLE && instr_req && !instr_grant) time_req_q <= counter;
        end
    end

    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_IDLE:     if (instr_req && !instr_grant) state_d = REQ_WAIT_GNT;
            REQ_WAIT_GNT: if (instr_grant)               state_d = REQ_IDLE;
            default:                                     state_d = REQ_IDLE;
        endcase
    end

    trace_fifo #(
        .WIDTH ($bits(pending_entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_granted),
        .pop   (instr_rvalid),
        .din   (pend_in),
        .dout  (pend_head),
        .full  (pend_full),
        .empty (pend_empty)
    );

    trace_fifo #(
        .WIDTH ($bits(fetch_record_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_hit),
        .pop   (out_pop),
        .din   (rec_in),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding  <= '0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            outstanding <= outstanding + OCW'(pend_accept) - OCW'(pend_hit);
            if (grant_drop || rec_drop)        overflow     <= 1'b1;
            if (instr_rvalid && pend_empty)    protocol_err <= 1'b1;
        end
    end

`ifdef FETCH_TRACKER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if ((grant_drop || rec_drop) && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
